cam_soc_pio_in: RTL and testbench
=================================

CAM_SOC_PIO_IN -- requirements
Module: cam_soc_pio_in

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input port width, legal range 1..32.
REQ-002 SHALL have parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: debounce length, legal range 2..65535.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port address, input, 2: Avalon-MM register select.
REQ-007 SHALL have port chipselect, input, 1: Avalon slave select.
REQ-008 SHALL have port write_n, input, 1: active-low write strobe.
REQ-009 SHALL have port writedata, input, 32: write data.
REQ-010 SHALL have port in_port, input, WIDTH: asynchronous external inputs.
REQ-011 SHALL have port readdata, output, 32: registered read data, zero-extended above WIDTH.
REQ-012 SHALL have port irq, output, 1: level interrupt request.

Function
REQ-013 SHALL implement this register map:
- 0: DATA, read-only, filtered input value.
- 1: IRQ_MASK, read/write, WIDTH bits.
- 2: reserved, reads 0.
- 3: EDGE_CAP, read / write-1-to-clear.
REQ-014 SHALL pass in_port through a 2-flop synchronizer (s1, s2) per bit.
REQ-015 SHALL update readdata every clk edge from the current address, regardless of chipselect.
- Read latency: 1 cycle.
- Bits 31..WIDTH always 0.
REQ-016 SHALL perform a write when chipselect=1 and write_n=0; writes to addresses 0 and 2 are ignored.
REQ-017 SHALL, without debounce, make an in_port change visible in readdata (address 0) at the 3rd clk edge after the change.
REQ-018 SHALL keep prev, the filtered value delayed one cycle, and detect an edge per bit:
- EDGE_TYPE 0: filt & ~prev.
- EDGE_TYPE 1: ~filt & prev.
- EDGE_TYPE 2: filt ^ prev.
REQ-019 SHALL set the corresponding EDGE_CAP bit on the cycle an edge is detected; the bit stays set until cleared.
REQ-020 SHALL clear an EDGE_CAP bit when it is written with 1; writing 0 leaves the bit unchanged.
REQ-021 SHALL keep an EDGE_CAP bit set when an edge detection and a W1C hit that bit in the same cycle (set wins).
REQ-022 SHALL drive irq = OR over (EDGE_CAP & IRQ_MASK), taken directly from registers with no added latency.
REQ-023 SHALL suppress edge detection until a 2-bit startup counter saturates at 3 after reset, so spurious edges from synchronizer fill are never captured.
REQ-024 SHALL apply IRQ_MASK writes from the next cycle; unmasking a bit already set in EDGE_CAP asserts irq on that next cycle.

Reset
REQ-025 SHALL, while reset_n=0, hold the following at 0: s1, s2, filtered value, prev, debounce counters, startup counter, IRQ_MASK, EDGE_CAP, readdata, irq.
REQ-026 SHALL restart the startup counter when reset is asserted mid-operation; captured edges are lost.

Configuration
REQ-027 SHALL, with macro CAM_SOC_PIO_IN_DEBOUNCE_EN defined, filter each bit with a per-bit counter:
- Counter increments while s2 != filtered value and clears when they are equal.
- On the DEBOUNCE_CYCLES-th consecutive differing cycle, the filtered value takes s2 and the counter clears.
REQ-028 SHALL, without CAM_SOC_PIO_IN_DEBOUNCE_EN, use filtered value = s2, and DEBOUNCE_CYCLES SHALL have no effect.

Structure
REQ-029 SHALL place the following in shared package cam_soc_pio_pkg:
- Register address constants (DATA, IRQ_MASK, EDGE_CAP).
- EDGE_TYPE encoding constants.
REQ-030 SHALL implement debounce as sub-module cam_soc_pio_debounce (1 bit, counter width derived from DEBOUNCE_CYCLES), instantiated per bit only when the macro is defined.

Verification
REQ-031 SHALL cover: WIDTH=8, no debounce, in_port 0x00->0xA5, address=0 -> readdata=0x000000A5 at the 3rd edge; bits 31..8 = 0.
REQ-032 SHALL cover: EDGE_TYPE=0, IRQ_MASK=0x01, in_port bit0 rising -> EDGE_CAP=0x01 and irq=1; W1C 0x01 -> irq=0 on the next cycle.
REQ-033 SHALL cover: W1C of bit 2 issued in the same cycle a bit-2 edge is detected -> EDGE_CAP bit 2 stays 1.
REQ-034 SHALL cover: in_port=0xFF held through reset release -> EDGE_CAP=0x00 and irq=0 for 10 cycles.
REQ-035 SHALL cover: with debounce defined, DEBOUNCE_CYCLES=4, bit0 pulsed high for 3 cycles -> DATA bit0 stays 0; held for 4+ cycles -> DATA bit0=1.
REQ-036 SHALL cover: EDGE_TYPE=2, IRQ_MASK=0, toggle bit 3 -> EDGE_CAP=0x08 and irq=0; then write IRQ_MASK=0x08 -> irq=1 on the next cycle.

Source files
------------

// File: rtl/cam_soc_pio_pkg.sv
// Shared constants for the Avalon-MM PIO input block: register map and edge-type encoding.
package cam_soc_pio_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  // EDGE_TYPE parameter encoding
  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Startup counter value at which edge capture becomes live
  localparam logic [1:0] STARTUP_DONE = 2'd3;

endpackage

// File: rtl/cam_soc_pio_debounce.sv
// Single-bit debounce filter: the output follows the input only after the input has
// differed from the output for DEBOUNCE_CYCLES consecutive clocks.
module cam_soc_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1 before the output flips.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            filt_d, filt_q;

  // Count consecutive differing cycles; accept the input on the last one.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (d_i != filt_q) begin
      if (cnt_q == CntMax) begin
        filt_d = d_i;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Filter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign q_o = filt_q;

endmodule

// File: rtl/cam_soc_pio_in.sv
// Avalon-MM parallel input port with synchronizer, optional per-bit debounce
// (enabled by defining CAM_SOC_PIO_IN_DEBOUNCE_EN), edge capture and masked level irq.
module cam_soc_pio_in #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  import cam_soc_pio_pkg::*;

  logic [WIDTH-1:0] s1_d, s1_q, s2_d, s2_q;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_d, prev_q;
  logic [WIDTH-1:0] mask_d, mask_q;
  logic [WIDTH-1:0] cap_d, cap_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] w1c;
  logic [1:0]       startup_d, startup_q;
  logic [31:0]      readdata_d, readdata_q;
  logic             wr_en;

  // Upper write-data bits are not stored when WIDTH < 32.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

`ifdef CAM_SOC_PIO_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    cam_soc_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .d_i    (s2_q[i]),
      .q_o    (filt[i])
    );
  end
`else
  assign filt = s2_q;
  logic [31:0] unused_debounce_cycles;
  assign unused_debounce_cycles = 32'(DEBOUNCE_CYCLES);
`endif

  assign wr_en = chipselect && !write_n;

  // Edge detection, held off until the synchronizer has filled after reset
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISING:  edge_det = filt & ~prev_q;
      EDGE_FALLING: edge_det = ~filt & prev_q;
      default:      edge_det = filt ^ prev_q;
    endcase
    if (startup_q != STARTUP_DONE) begin
      edge_det = '0;
    end
  end

  // Register writes, edge capture (set beats W1C), startup count and read mux
  always_comb begin
    s1_d      = in_port;
    s2_d      = s1_q;
    prev_d    = filt;
    startup_d = (startup_q == STARTUP_DONE) ? startup_q : startup_q + 2'd1;

    mask_d = mask_q;
    if (wr_en && address == ADDR_IRQ_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end

    w1c = '0;
    if (wr_en && address == ADDR_EDGE_CAP) begin
      w1c = writedata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~w1c) | edge_det;

    readdata_d = '0;
    case (address)
      ADDR_DATA:     readdata_d[WIDTH-1:0] = filt;
      ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = cap_q;
      default:       readdata_d = '0;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      startup_q  <= '0;
      readdata_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      startup_q  <= startup_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_cam_soc_pio_in.sv
// Scoreboard bench for cam_soc_pio_in: one rising-edge and one any-edge instance share stimulus;
// a reference model predicts readdata/irq per clock and a monitor compares on each falling edge.
module tb_cam_soc_pio_in;

  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [7:0]  inp = 8'd0;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;

  typedef struct packed {
    logic [31:0] rd0;
    logic [31:0] rd2;
    logic        irq0;
    logic        irq2;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model state
  logic [7:0] seen0, seen1;   // in_port at the last edge, and the edge before
  logic [7:0] m_filt, m_prev, m_mask, m_cap0, m_cap2;
  int         n_edges;        // edges since reset release, saturating
  int         db_cnt[8];

  always #5 clk = ~clk;

  cam_soc_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut0 (
    .clk       (clk),
    .reset_n   (rst_n),
    .address   (addr),
    .chipselect(cs),
    .write_n   (wn),
    .writedata (wdata),
    .in_port   (inp),
    .readdata  (rd0),
    .irq       (irq0)
  );

  cam_soc_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) dut2 (
    .clk       (clk),
    .reset_n   (rst_n),
    .address   (addr),
    .chipselect(cs),
    .write_n   (wn),
    .writedata (wdata),
    .in_port   (inp),
    .readdata  (rd2),
    .irq       (irq2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a, input logic [7:0] cap);
    case (a)
      2'd0:    return {24'd0, m_filt};
      2'd1:    return {24'd0, m_mask};
      2'd3:    return {24'd0, cap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    seen0 = 0; seen1 = 0; m_filt = 0; m_prev = 0; m_mask = 0; m_cap0 = 0; m_cap2 = 0;
    n_edges = 0;
    for (int i = 0; i < 8; i++) db_cnt[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented before that edge.
  task automatic model_update();
    exp_t       e;
    logic [7:0] w1c, rise, fall;
    if (!rst_n) begin
      model_reset();
      e = '0;
    end else begin
      e.rd0 = model_read(addr, m_cap0);
      e.rd2 = model_read(addr, m_cap2);
      w1c  = (cs && !wn && addr == 2'd3) ? wdata[7:0] : 8'd0;
      rise = m_filt & ~m_prev;
      fall = ~m_filt & m_prev;
      if (n_edges < 3) begin
        rise = 0;
        fall = 0;
      end
      m_cap0 = (m_cap0 & ~w1c) | rise;
      m_cap2 = (m_cap2 & ~w1c) | rise | fall;
      if (cs && !wn && addr == 2'd1) m_mask = wdata[7:0];
      m_prev = m_filt;
`ifdef CAM_SOC_PIO_IN_DEBOUNCE_EN
      for (int i = 0; i < 8; i++) begin
        if (seen1[i] != m_filt[i]) begin
          if (db_cnt[i] == DB - 1) begin
            m_filt[i] = seen1[i];
            db_cnt[i] = 0;
          end else begin
            db_cnt[i]++;
          end
        end else begin
          db_cnt[i] = 0;
        end
      end
`else
      m_filt = seen0;
`endif
      seen1 = seen0;
      seen0 = inp;
      if (n_edges < 3) n_edges++;
      e.irq0 = |(m_cap0 & m_mask);
      e.irq2 = |(m_cap2 & m_mask);
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic c, input logic w_n, input logic [1:0] a,
                      input logic [31:0] wd, input logic [7:0] ip);
    @(negedge clk);
    #1;
    rst_n = r; cs = c; wn = w_n; addr = a; wdata = wd; inp = ip;
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input logic [1:0] a, input logic [7:0] ip);
    step(1'b1, 1'b0, 1'b1, a, 32'd0, ip);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, a, d, inp);
  endtask

  // Monitor: compare every prediction against the DUT outputs away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("readdata_rise", rd0, e.rd0);
        chk("readdata_any", rd2, e.rd2);
        chk("irq_rise", {31'd0, irq0}, {31'd0, e.irq0});
        chk("irq_any", {31'd0, irq2}, {31'd0, e.irq2});
      end
    end
  end

  initial begin
    logic [7:0] ni;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 8'h00);
    repeat (6) idle(2'd0, 8'h00);

    // Input 0x00 -> 0xA5 appears on DATA at the third edge
    idle(2'd0, 8'hA5);
`ifndef CAM_SOC_PIO_IN_DEBOUNCE_EN
    idle(2'd0, 8'hA5);
    #1 chk("data_before_3rd_edge", rd0, 32'h0000_0000);
    idle(2'd0, 8'hA5);
    #1 chk("data_at_3rd_edge", rd0, 32'h0000_00A5);
`endif
    repeat (10) idle(2'd0, 8'hA5);
    repeat (10) idle(2'd0, 8'h00);
    wr(2'd3, 32'hFF);
    wr(2'd1, 32'h01);

    // Rising bit0 with mask bit0 set raises irq; W1C drops it on the next edge
    idle(2'd3, 8'h01);
    repeat (9) idle(2'd3, 8'h01);
    #1 chk("cap_bit0_set", rd0, 32'h0000_0001);
    chk("irq_after_rise", {31'd0, irq0}, 32'd1);
    wr(2'd3, 32'h01);
    #1 chk("irq_after_w1c", {31'd0, irq0}, 32'd0);

    // W1C on bit2 in the same cycle its edge is detected: set wins
    wr(2'd1, 32'h00);
    idle(2'd3, 8'h05);
    idle(2'd3, 8'h05);
    wr(2'd3, 32'h04);
    idle(2'd3, 8'h05);
`ifndef CAM_SOC_PIO_IN_DEBOUNCE_EN
    #1 chk("cap_set_beats_w1c", rd0 & 32'h4, 32'h4);
`endif

    // Any-edge: toggle bit3 with mask clear, then unmask
    repeat (10) idle(2'd3, 8'h05);
    wr(2'd3, 32'hFF);
    wr(2'd1, 32'h00);
    idle(2'd3, 8'h0D);
    repeat (9) idle(2'd3, 8'h0D);
    #1 chk("cap_any_bit3", rd2, 32'h0000_0008);
    chk("irq_any_masked", {31'd0, irq2}, 32'd0);
    wr(2'd1, 32'h08);
    #1 chk("irq_any_unmasked", {31'd0, irq2}, 32'd1);

    // In_port 0xFF held through reset release: no spurious capture
    repeat (3) step(1'b0, 1'b0, 1'b1, 2'd3, 32'd0, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 2'd1, 32'hFF, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      idle(2'd3, 8'hFF);
`ifndef CAM_SOC_PIO_IN_DEBOUNCE_EN
      #1 chk("no_cap_after_reset", rd0 | rd2 | {31'd0, irq0 | irq2}, 32'd0);
`endif
    end

`ifdef CAM_SOC_PIO_IN_DEBOUNCE_EN
    // Three-cycle glitch is rejected, four-plus-cycle level is accepted
    repeat (12) idle(2'd0, 8'h00);
    repeat (3) idle(2'd0, 8'h01);
    for (int k = 0; k < 10; k++) begin
      idle(2'd0, 8'h00);
      #1 chk("debounce_glitch", rd0 & 32'h1, 32'h0);
    end
    repeat (12) idle(2'd0, 8'h01);
    #1 chk("debounce_accept", rd0 & 32'h1, 32'h1);
`endif

    // Randomized traffic with occasional mid-run reset
    for (int k = 0; k < 500; k++) begin
      ni = inp;
      if ($urandom_range(0, 3) == 0) ni = ni ^ 8'($urandom_range(0, 255));
      if ($urandom_range(0, 149) == 0) begin
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, ni);
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, ni);
      end else if ($urandom_range(0, 3) == 0) begin
        step(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom, ni);
      end else begin
        step(1'b1, $urandom_range(0, 1) == 1, 1'b1, 2'($urandom_range(0, 3)), 32'd0, ni);
      end
    end

    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
